// File: rtl/cdc_fifo_pkg.sv
// Shared types and constants for the cdc_fifo write-side arbiter.
// State encoding doubles as the one-hot grant vector.
package cdc_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_t;

  localparam int unsigned BEAT_CNT_W = 8;

  function automatic logic [1:0] grant_of(arb_state_t s);
    return (s == OWN0) ? 2'b01 : (s == OWN1) ? 2'b10 : 2'b00;
  endfunction

endpackage

// File: rtl/cdc_fifo_write_arbiter_if.sv
// Requester, FIFO write-side and debug signals of the write arbiter.
// master = requesters/FIFO side, slave = arbiter.
interface cdc_fifo_write_arbiter_if
  import cdc_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4
);

  logic                  req0_valid;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_last;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_last;
  logic                  req1_ready;
  logic                  full;
  logic                  write_increment;
  logic [DATA_WIDTH-1:0] write_data;
  logic [1:0]            grant;
  logic [BEAT_CNT_W-1:0] beats0;
  logic [BEAT_CNT_W-1:0] beats1;

  modport master (
    output req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last, full,
    input  req0_ready, req1_ready, write_increment, write_data, grant, beats0, beats1
  );

  modport slave (
    input  req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last, full,
    output req0_ready, req1_ready, write_increment, write_data, grant, beats0, beats1
  );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin choice: prio breaks a tie, otherwise the lone valid wins.
module rr_pick2 (
  input  logic valid0,
  input  logic valid1,
  input  logic prio,
  output logic any_valid,
  output logic pick
);

  always_comb begin
    any_valid = valid0 | valid1;
    pick      = (valid0 & valid1) ? prio : valid1;
  end

endmodule

// File: rtl/cdc_fifo_write_arbiter.sv
// Round-robin, burst-locked arbiter sharing the cdc_fifo write port between two
// requesters; drives the FIFO push directly and keeps per-requester beat counts.
module cdc_fifo_write_arbiter
  import cdc_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned MAX_BURST  = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  cdc_fifo_write_arbiter_if.slave bus
);

  arb_state_t            state_q, state_d;
  logic                  prio_q, prio_d;
  logic [3:0]            burst_cnt_q, burst_cnt_d;
  logic [BEAT_CNT_W-1:0] beats0_q, beats0_d;
  logic [BEAT_CNT_W-1:0] beats1_q, beats1_d;

  logic                  own0, own1, idle;
  logic                  ready0, ready1;
  logic                  accept0, accept1, accept;
  logic                  own_last;
  logic [DATA_WIDTH-1:0] own_data;
  logic [3:0]            burst_inc;
  logic                  release_burst;
  logic                  pick_v0, pick_v1, pick_any, pick;

  assign idle = (state_q == IDLE);
  assign own0 = (state_q == OWN0);
  assign own1 = (state_q == OWN1);

  // Gating with rst_n keeps a beat in the reset cycle from reaching the FIFO.
  assign ready0  = own0 & ~bus.full & rst_n;
  assign ready1  = own1 & ~bus.full & rst_n;
  assign accept0 = bus.req0_valid & ready0;
  assign accept1 = bus.req1_valid & ready1;
  assign accept  = accept0 | accept1;

  assign own_last  = (own0 & bus.req0_last) | (own1 & bus.req1_last);
  assign own_data  = own0 ? bus.req0_data : own1 ? bus.req1_data : '0;
  assign burst_inc = burst_cnt_q + 4'd1;

  assign release_burst = accept & (own_last | (burst_inc == 4'(MAX_BURST)));

  // In IDLE both requesters compete; on release only the other one may take over.
  assign pick_v0 = bus.req0_valid & (idle | own1);
  assign pick_v1 = bus.req1_valid & (idle | own0);

  rr_pick2 u_rr_pick2 (
    .valid0    (pick_v0),
    .valid1    (pick_v1),
    .prio      (prio_q),
    .any_valid (pick_any),
    .pick      (pick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) state_d = pick ? OWN1 : OWN0;
      end
      OWN0, OWN1: begin
        if (release_burst) begin
          state_d = pick_any ? (pick ? OWN1 : OWN0) : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    bus.req0_ready      = ready0;
    bus.req1_ready      = ready1;
    bus.write_increment = accept;
    bus.write_data      = own_data;
    bus.grant           = grant_of(state_q);
    bus.beats0          = beats0_q;
    bus.beats1          = beats1_q;
  end

  // Datapath next-state.
  always_comb begin
    prio_d      = release_burst ? own0 : prio_q;
    burst_cnt_d = burst_cnt_q;
    if (state_d != state_q) begin
      burst_cnt_d = 4'd0;
    end else if (accept) begin
      burst_cnt_d = burst_inc;
    end
    beats0_d = beats0_q + {{(BEAT_CNT_W-1){1'b0}}, accept0};
    beats1_d = beats1_q + {{(BEAT_CNT_W-1){1'b0}}, accept1};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q      <= 1'b0;
      burst_cnt_q <= 4'd0;
      beats0_q    <= '0;
      beats1_q    <= '0;
    end else begin
      prio_q      <= prio_d;
      burst_cnt_q <= burst_cnt_d;
      beats0_q    <= beats0_d;
      beats1_q    <= beats1_d;
    end
  end

endmodule
